seq_code_checker: RTL

- Receive-side checker for the 3-bit cyclic code stream produced by the team's code generators.
- Samples one code per valid cycle, acquires lock onto a fixed 4-entry repeating sequence, then flywheels through it.
- Counts good words and errors, flags each mismatch, and declares loss of lock after repeated misses.
- Sits on the consumer side of the generator, as a self-check/monitor block.

---
 rtl/seq_code_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/seq_code_checker.sv
// seq_code_checker: receive-side monitor for the 3-bit cyclic code stream.
// It hunts for the SEQ0 anchor, needs LOCK_N consecutive in-order codes to
// declare lock, then flywheels through the 4-entry sequence. While locked it
// counts good and bad words and drops lock after LOSS_N consecutive misses.
// Handshake: in_valid qualifies in_code for one cycle; there is no
// backpressure, so every cycle with in_valid=1 is one accepted code.
module seq_code_checker #(
    parameter int              W      = 3,
    parameter logic [W-1:0]    SEQ0   = 3'b101,
    parameter logic [W-1:0]    SEQ1   = 3'b111,
    parameter logic [W-1:0]    SEQ2   = 3'b010,
    parameter logic [W-1:0]    SEQ3   = 3'b011,
    parameter int              LOCK_N = 4,
    parameter int              LOSS_N = 2,
    parameter int              CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_code,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [W-1:0]     exp_code,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N4 = 4'(LOCK_N);
    localparam logic [3:0] LOSS_N4 = 4'(LOSS_N);

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [3:0]       r_good;
    logic [3:0]       r_miss;
    logic             r_locked;
    logic             r_err_pulse;
    logic [W-1:0]     r_exp_code;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [1:0]       w_idx_inc;
    logic [W-1:0]     w_exp_now;
    logic [W-1:0]     w_exp_inc;
    logic             w_match;
    logic [3:0]       w_good_inc;
    logic [3:0]       w_miss_inc;
    logic             w_word_inc;
    logic             w_err_inc;

    function automatic logic [W-1:0] seq_at(input logic [1:0] idx);
        case (idx)
            2'd0:    seq_at = SEQ0;
            2'd1:    seq_at = SEQ1;
            2'd2:    seq_at = SEQ2;
            default: seq_at = SEQ3;
        endcase
    endfunction

    assign w_idx_inc  = r_idx + 2'd1;
    assign w_exp_now  = seq_at(r_idx);
    assign w_exp_inc  = seq_at(w_idx_inc);
    assign w_match    = (in_code == w_exp_now);
    assign w_good_inc = r_good + 4'd1;
    assign w_miss_inc = r_miss + 4'd1;
    assign w_word_inc = in_valid && (r_state == ST_LOCKED) && w_match;
    assign w_err_inc  = in_valid && (r_state == ST_LOCKED) && !w_match;

    // Lock FSM: hunt for the anchor, confirm alignment, then flywheel while locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_idx       <= 2'd0;
            r_good      <= 4'd0;
            r_miss      <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_exp_code  <= SEQ0;
        end else begin
            r_err_pulse <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (in_code == SEQ0) begin
                            r_idx      <= 2'd1;
                            r_exp_code <= SEQ1;
                            r_good     <= 4'd1;
                            if (LOCK_N4 == 4'd1) begin
                                r_state  <= ST_LOCKED;
                                r_miss   <= 4'd0;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= ST_SYNC;
                            end
                        end else begin
                            r_idx      <= 2'd0;
                            r_exp_code <= SEQ0;
                        end
                    end
                    ST_SYNC: begin
                        if (w_match) begin
                            r_idx      <= w_idx_inc;
                            r_exp_code <= w_exp_inc;
                            r_good     <= w_good_inc;
                            if (w_good_inc == LOCK_N4) begin
                                r_state  <= ST_LOCKED;
                                r_miss   <= 4'd0;
                                r_locked <= 1'b1;
                            end
                        end else if (in_code == SEQ0) begin
                            // A fresh anchor mid-sync restarts alignment here.
                            r_idx      <= 2'd1;
                            r_exp_code <= SEQ1;
                            r_good     <= 4'd1;
                        end else begin
                            r_state    <= ST_HUNT;
                            r_idx      <= 2'd0;
                            r_exp_code <= SEQ0;
                            r_good     <= 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        r_err_pulse <= !w_match;
                        if (w_match) begin
                            r_idx      <= w_idx_inc;
                            r_exp_code <= w_exp_inc;
                            r_miss     <= 4'd0;
                        end else if (w_miss_inc == LOSS_N4) begin
                            r_state    <= ST_HUNT;
                            r_locked   <= 1'b0;
                            r_idx      <= 2'd0;
                            r_exp_code <= SEQ0;
                            r_good     <= 4'd0;
                            r_miss     <= 4'd0;
                        end else begin
                            // Flywheel: keep stepping, never realign on a miss.
                            r_idx      <= w_idx_inc;
                            r_exp_code <= w_exp_inc;
                            r_miss     <= w_miss_inc;
                        end
                    end
                    default: begin
                        r_state    <= ST_HUNT;
                        r_idx      <= 2'd0;
                        r_exp_code <= SEQ0;
                        r_good     <= 4'd0;
                        r_miss     <= 4'd0;
                        r_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating word/error counters; clr_cnt beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_word_inc && (r_word_cnt != '1))
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            if (w_err_inc && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign exp_code  = r_exp_code;
    assign word_cnt  = r_word_cnt;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

endmodule
